// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: sweep FSM states and
// default geometry used by the register file, issue and write-back stages.
package reg_file_mp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned NRD_DEF  = 2;
  localparam int unsigned NWR_DEF  = 2;

  // Address width for a register file of nreg entries (minimum 1 bit).
  function automatic int unsigned addr_width(input int unsigned nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/reg_file_mp_sb.sv
// Busy scoreboard: one bit per architectural register, set on issue and
// cleared on write-back or flush; looked up by every read port.
module reg_file_sb
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NRD      = NRD_DEF,
  parameter int unsigned NWR      = NWR_DEF,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = addr_width(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  // Next busy vector: write-back clears, flush clears all, issue sets last so
  // a newly issued producer survives a same-cycle write-back or flush.
  always_comb begin
    busy_next = busy;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (wr_en[k]) busy_next[wr_addr[k*AW +: AW]] = 1'b0;
    end
    if (flush) busy_next = '0;
    if (iss_en && !(ZERO_REG && iss_addr == '0)) busy_next[iss_addr] = 1'b1;
  end

  // Scoreboard register; frozen while the clear sweep runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (run) begin
      busy <= busy_next;
    end
  end

  // Per-port lookup, masked when a same-cycle write forwards the data.
  always_comb begin
    rd_busy = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_busy[p] = run && busy[rd_addr[p*AW +: AW]];
      if (BYPASS) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wr_en[k] && wr_addr[k*AW +: AW] == rd_addr[p*AW +: AW]) rd_busy[p] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-priority, optional write->read
// bypass, hardwired zero register, busy scoreboard and a post-reset clear sweep.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NRD      = NRD_DEF,
  parameter int unsigned NWR      = NWR_DEF,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush
);

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] mem [NREG];
  logic [NWR-1:0]  wr_keep;
  logic            run;

  assign run = (state == ST_RUN);

  // Clear-sweep FSM: walk every entry once after reset, then enter RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(NREG - 1)) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end
  end

  // Write arbitration: drop writes to the zero register and any port that a
  // younger (higher-index) enabled port overrides on the same address.
  always_comb begin
    wr_keep = '0;
    for (int unsigned k = 0; k < NWR; k++) begin
      wr_keep[k] = wr_en[k] && !(ZERO_REG && wr_addr[k*AW +: AW] == '0);
      for (int unsigned j = k + 1; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW]) wr_keep[k] = 1'b0;
      end
    end
  end

  // Storage: zero one entry per cycle during the sweep, else commit writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wr_keep[k]) mem[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Read ports: array lookup, then youngest hitting write port when bypass
  // is enabled, then zero-register and sweep masking.
  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_data[p*XLEN +: XLEN] = mem[rd_addr[p*AW +: AW]];
      if (BYPASS) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wr_en[k] && wr_addr[k*AW +: AW] == rd_addr[p*AW +: AW]) begin
            rd_data[p*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
          end
        end
      end
      if (!run || (ZERO_REG && rd_addr[p*AW +: AW] == '0)) rd_data[p*XLEN +: XLEN] = '0;
    end
  end

  reg_file_sb #(
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (bypass on / off) share stimulus and
// are compared against an array-based reference model of the register file.
module tb_reg_file_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [2*AW-1:0]   rd_addr;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;

  logic              init_a, init_b;
  logic [2*XLEN-1:0] rdd_a, rdd_b;
  logic [1:0]        rdb_a, rdb_b;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  bit              m_run;
  int              m_cnt;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .rst(rst), .init_done(init_a), .rd_addr(rd_addr), .rd_data(rdd_a),
    .rd_busy(rdb_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush));

  reg_file_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst(rst), .init_done(init_b), .rd_addr(rd_addr), .rd_data(rdd_b),
    .rd_busy(rdb_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush));

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register contents as seen by a reader: zero outside RUN and for x0,
  // otherwise the stored word or, with forwarding, the youngest write to it.
  function automatic logic [63:0] exp_rd(input int p, input bit byp);
    logic [AW-1:0] a;
    logic [63:0]   v;
    a = rd_addr[p*AW +: AW];
    if (!m_run || a == 0) return 64'd0;
    v = m_mem[a];
    if (byp)
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == a) v = wr_data[k*XLEN +: XLEN];
    return v;
  endfunction

  function automatic bit exp_busy(input int p, input bit byp);
    logic [AW-1:0] a;
    a = rd_addr[p*AW +: AW];
    if (!m_run) return 1'b0;
    if (byp)
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_check();
    check64("init_done_a", {63'd0, init_a}, {63'd0, m_run});
    check64("init_done_b", {63'd0, init_b}, {63'd0, m_run});
    for (int p = 0; p < 2; p++) begin
      check64($sformatf("rd_data_a[%0d]", p), rdd_a[p*XLEN +: XLEN], exp_rd(p, 1'b1));
      check64($sformatf("rd_data_b[%0d]", p), rdd_b[p*XLEN +: XLEN], exp_rd(p, 1'b0));
      check64($sformatf("rd_busy_a[%0d]", p), {63'd0, rdb_a[p]}, {63'd0, exp_busy(p, 1'b1)});
      check64($sformatf("rd_busy_b[%0d]", p), {63'd0, rdb_b[p]}, {63'd0, exp_busy(p, 1'b0)});
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (!m_run) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NREG) m_run = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k]) begin
          if (wr_addr[k*AW +: AW] != 0) m_mem[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
          m_busy[wr_addr[k*AW +: AW]] = 1'b0;
        end
      end
      if (flush) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle();
    wr_en = '0; iss_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0;
    iss_addr = '0; idle();
    m_run = 1'b0; m_cnt = 0;
    @(posedge clk); model_update(); #1;
    rst = 1'b0;

    // Sweep length after a single reset cycle
    n = 0;
    while (!init_a && n < 100) begin step(); n++; end
    check64("sweep_cycles", 64'(n), 64'd32);

    // All registers read zero after the sweep
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(i + 16), 5'(i)};
      settle();
      check64("swept_zero0", rdd_a[63:0], 64'd0);
      check64("swept_zero1", rdd_a[127:64], 64'd0);
      advance();
    end

    // Two ports write x5 in one cycle: the younger port wins
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {64'h2222, 64'h1111};
    step(); idle();
    rd_addr = {5'd0, 5'd5};
    settle(); check64("x5_priority", rdd_a[63:0], 64'h2222); advance();

    // Same-cycle write/read of x7 with a pending producer
    iss_en = 1'b1; iss_addr = 5'd7; step(); idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {64'd0, 64'hDEAD}; rd_addr = {5'd0, 5'd7};
    settle();
    check64("byp_data",    rdd_a[63:0], 64'hDEAD);
    check64("byp_busy",    {63'd0, rdb_a[0]}, 64'd0);
    check64("nobyp_data",  rdd_b[63:0], 64'd0);
    check64("nobyp_busy",  {63'd0, rdb_b[0]}, 64'd1);
    advance(); idle();

    // Zero register ignores writes and issue
    wr_en = 2'b01; wr_addr = '0; wr_data = {64'd0, 64'hFFFF}; iss_en = 1'b1; iss_addr = 5'd0;
    step(); idle(); rd_addr = '0;
    settle();
    check64("x0_data", rdd_a[63:0], 64'd0);
    check64("x0_busy", {63'd0, rdb_a[0]}, 64'd0);
    advance();

    // Issue beats same-cycle write-back; flush+issue leaves only the new one
    iss_en = 1'b1; iss_addr = 5'd3; step(); idle();
    rd_addr = {5'd0, 5'd3};
    settle(); check64("x3_busy", {63'd0, rdb_a[0]}, 64'd1); advance();
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {64'h33, 64'd0};
    iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd0, 5'd9};
    step(); idle(); rd_addr = {5'd0, 5'd3};
    settle(); check64("x3_reissue_busy", {63'd0, rdb_a[0]}, 64'd1); advance();
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4; step(); idle();
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(i + 16), 5'(i)};
      settle();
      check64("flush_busy0", {63'd0, rdb_a[0]}, (i == 4) ? 64'd1 : 64'd0);
      check64("flush_busy1", {63'd0, rdb_a[1]}, 64'd0);
      advance();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      wr_en    = 2'($urandom);
      wr_addr  = 10'($urandom);
      if ($urandom_range(3) == 0) wr_addr[9:5] = wr_addr[4:0];
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      iss_en   = ($urandom_range(2) == 0);
      iss_addr = 5'($urandom);
      flush    = ($urandom_range(15) == 0);
      rd_addr  = 10'($urandom);
      if ($urandom_range(2) == 0) rd_addr[4:0] = wr_addr[4:0];
      if ($urandom_range(2) == 0) rd_addr[9:5] = wr_addr[9:5];
      step();
    end
    idle();

    // Reset in the middle of the sweep restarts it from entry 0
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_addr = 10'($urandom);
      step();
    end
    rst = 1'b1; step(); rst = 1'b0;
    n = 0;
    while (!init_a && n < 100) begin
      rd_addr = 10'($urandom);
      step(); n++;
    end
    check64("resweep_cycles", 64'(n), 64'd32);
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(i + 16), 5'(i)};
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
